// File: rtl/gray_pointer_receiver.sv
// gray_pointer_receiver: synchronize and decode a remote Gray pointer, track a local consumer pointer and report occupancy
module gray_pointer_receiver #(
    parameter int width      = 10,
    parameter int syncStages = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] grayIn,
    input  logic             ifc_advance__ENA,
    output logic             ifc_advance__RDY,
    input  logic             ifc_clearError__ENA,
    output logic             ifc_clearError__RDY,
    output logic [width-1:0] ifc_readBin,
    output logic             ifc_readBin__RDY,
    output logic [width-1:0] ifc_readGray,
    output logic             ifc_readGray__RDY,
    output logic [width-1:0] ifc_level,
    output logic             ifc_error
);
    localparam logic [2:0] WARM_CYCLES = 3'(syncStages + 1);
    logic [width-1:0] sync_q [syncStages];
    logic [width-1:0] gs;
    logic [width-1:0] gs_prev;
    logic [width-1:0] gs_bin;
    logic [width-1:0] step;
    logic [width-1:0] remote_bin;
    logic [width-1:0] local_bin;
    logic [width-1:0] local_gray;
    logic [width-1:0] next_local;
    logic [2:0]       warm;
    logic             check_en;
    logic             multi_bit;
    logic             take;
    logic             error;

    assign gs         = sync_q[syncStages-1];
    assign step       = gs ^ gs_prev;
    assign multi_bit  = |(step & (step - width'(1)));
    assign check_en   = warm == WARM_CYCLES;
    assign next_local = local_bin + width'(1);
    assign take       = ifc_advance__ENA && ifc_advance__RDY;

    assign ifc_level           = remote_bin - local_bin;
    assign ifc_advance__RDY    = ifc_level != '0;
    assign ifc_clearError__RDY = 1'b1;
    assign ifc_readBin         = remote_bin;
    assign ifc_readBin__RDY    = 1'b1;
    assign ifc_readGray        = local_gray;
    assign ifc_readGray__RDY   = 1'b1;
    assign ifc_error           = error;

    // binary bit i is the XOR of all Gray bits at or above i
    always_comb begin
        gs_bin = '0;
        for (int i = 0; i < width; i++) gs_bin[i] = ^(gs >> i);
    end

    // plain flop chain for the asynchronous Gray bus, nothing between stages
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < syncStages; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= grayIn;
            for (int i = 1; i < syncStages; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // decode the synchronized pointer and keep the previous sample for the step check
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gs_prev    <= '0;
            remote_bin <= '0;
        end else begin
            gs_prev    <= gs;
            remote_bin <= gs_bin;
        end
    end

    // hold off the step check until the synchronizer and gs_prev carry real samples
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) warm <= '0;
        else if (!check_en) warm <= warm + 3'd1;
    end

    // sticky error; a detection in the same cycle as a clear keeps it set
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) error <= 1'b0;
        else if (check_en && multi_bit) error <= 1'b1;
        else if (ifc_clearError__ENA) error <= 1'b0;
    end

    // local consumer pointer and its Gray image for the return crossing
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            local_bin  <= '0;
            local_gray <= '0;
        end else if (take) begin
            local_bin  <= next_local;
            local_gray <= next_local ^ (next_local >> 1);
        end
    end
endmodule

// File: tb/tb_gray_pointer_receiver.sv
// tb_gray_pointer_receiver: directed checks of sync latency, step error, local pointer and level
module tb_gray_pointer_receiver;
    logic       clk;
    logic       rst;
    logic [3:0] gray_in;
    logic       adv;
    logic       adv_rdy;
    logic       clr;
    logic       clr_rdy;
    logic [3:0] read_bin;
    logic       bin_rdy;
    logic [3:0] read_gray;
    logic       gray_rdy;
    logic [3:0] level;
    logic       error;
    int         vectors;
    int         miscompares;

    gray_pointer_receiver #(.width(4), .syncStages(2)) dut (
        .CLK(clk),
        .RST(rst),
        .grayIn(gray_in),
        .ifc_advance__ENA(adv),
        .ifc_advance__RDY(adv_rdy),
        .ifc_clearError__ENA(clr),
        .ifc_clearError__RDY(clr_rdy),
        .ifc_readBin(read_bin),
        .ifc_readBin__RDY(bin_rdy),
        .ifc_readGray(read_gray),
        .ifc_readGray__RDY(gray_rdy),
        .ifc_level(level),
        .ifc_error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] seq_a [4];
        logic [3:0] gray_exp [4];
        logic [3:0] seq_b [7];
        seq_a    = '{4'h1, 4'h3, 4'h2, 4'h6};
        gray_exp = '{4'h1, 4'h3, 4'h2, 4'h6};
        seq_b    = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4};
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        gray_in = 4'h0;
        adv = 1'b0;
        clr = 1'b0;
        #2;
        chk("rst_bin", 16'(read_bin), 16'h0);
        chk("rst_level", 16'(level), 16'h0);
        chk("rst_rdy", 16'(adv_rdy), 16'h0);
        chk("rst_gray", 16'(read_gray), 16'h0);
        chk("rst_err", 16'(error), 16'h0);
        chk("const_rdys", 16'({clr_rdy, bin_rdy, gray_rdy}), 16'h7);
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("idle_bin", 16'(read_bin), 16'h0);
        chk("idle_level", 16'(level), 16'h0);
        chk("idle_err", 16'(error), 16'h0);
        for (int k = 0; k < 4; k++) begin
            gray_in = seq_a[k];
            tick(2);
            chk("lat_hold", 16'(read_bin), 16'(k));
            tick(1);
            chk("lat_bin", 16'(read_bin), 16'(k + 1));
        end
        chk("seq_level", 16'(level), 16'h4);
        chk("seq_rdy", 16'(adv_rdy), 16'h1);
        chk("seq_err", 16'(error), 16'h0);
        adv = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("adv_gray", 16'(read_gray), 16'(gray_exp[k]));
            chk("adv_level", 16'(level), 16'(3 - k));
        end
        chk("adv_rdy_low", 16'(adv_rdy), 16'h0);
        tick(1);
        adv = 1'b0;
        chk("ign_gray", 16'(read_gray), 16'h6);
        chk("ign_level", 16'(level), 16'h0);
        chk("ign_err", 16'(error), 16'h0);
        for (int b = 5; b <= 14; b++) begin
            gray_in = 4'(b ^ (b >> 1));
            tick(1);
        end
        tick(3);
        chk("climb_bin", 16'(read_bin), 16'he);
        chk("climb_level", 16'(level), 16'ha);
        adv = 1'b1;
        tick(10);
        adv = 1'b0;
        chk("l14_gray", 16'(read_gray), 16'h9);
        chk("l14_level", 16'(level), 16'h0);
        gray_in = 4'h8;
        tick(3);
        chk("wrap15_bin", 16'(read_bin), 16'hf);
        chk("wrap15_level", 16'(level), 16'h1);
        gray_in = 4'h0;
        tick(3);
        chk("wrap0_bin", 16'(read_bin), 16'h0);
        chk("wrap0_level", 16'(level), 16'h2);
        adv = 1'b1;
        tick(1);
        chk("wrap_gray15", 16'(read_gray), 16'h8);
        chk("wrap_level1", 16'(level), 16'h1);
        tick(1);
        adv = 1'b0;
        chk("wrap_gray0", 16'(read_gray), 16'h0);
        chk("wrap_level0", 16'(level), 16'h0);
        chk("wrap_err", 16'(error), 16'h0);
        gray_in = 4'h3;
        tick(2);
        chk("jump_early", 16'(error), 16'h0);
        tick(1);
        chk("jump_err", 16'(error), 16'h1);
        chk("jump_level", 16'(level), 16'h2);
        gray_in = 4'h0;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("set_wins", 16'(error), 16'h1);
        chk("jump_back_bin", 16'(read_bin), 16'h0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_alone", 16'(error), 16'h0);
        for (int k = 0; k < 7; k++) begin
            gray_in = seq_b[k];
            tick(1);
        end
        tick(3);
        chk("pre_rst_bin", 16'(read_bin), 16'h7);
        adv = 1'b1;
        tick(2);
        adv = 1'b0;
        chk("pre_rst_gray", 16'(read_gray), 16'h3);
        chk("pre_rst_level", 16'(level), 16'h5);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_bin", 16'(read_bin), 16'h0);
        chk("mid_rst_level", 16'(level), 16'h0);
        chk("mid_rst_rdy", 16'(adv_rdy), 16'h0);
        chk("mid_rst_gray", 16'(read_gray), 16'h0);
        chk("mid_rst_err", 16'(error), 16'h0);
        gray_in = 4'h5;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);
        chk("post_rst_hold", 16'(read_bin), 16'h0);
        tick(1);
        chk("post_rst_bin", 16'(read_bin), 16'h6);
        chk("post_rst_level", 16'(level), 16'h6);
        chk("post_rst_err", 16'(error), 16'h0);
        tick(4);
        chk("post_rst_err_late", 16'(error), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gray_pointer_receiver.md
Name: gray_pointer_receiver

Overview:
Receive side of a Gray-coded pointer crossing. It samples a Gray count driven from another clock domain by the Gray up/down counter, synchronizes it, and decodes it to binary. It also checks that the count never changes by more than one bit per sample. It keeps a local binary consumer pointer and reports occupancy between the remote and local pointers, as used on the read side of an async FIFO. The local pointer is exported Gray-coded for the return crossing.

Parameters:
width, 10, pointer width in bits (2..16)
syncStages, 2, synchronizer flops on the incoming Gray bus (2..4)

Ports:
CLK  input  1  local clock; the only clock
RST  input  1  reset, asynchronous, active-high; clears all state immediately
grayIn  input  width  remote Gray pointer, asynchronous to CLK
ifc$advance__ENA  input  1  consume one entry; increment the local pointer
ifc$advance__RDY  output  1  high when level != 0
ifc$clearError__ENA  input  1  clear the sticky error flag
ifc$clearError__RDY  output  1  constant 1
ifc$readBin  output  width  decoded remote pointer (binary, registered)
ifc$readBin__RDY  output  1  constant 1
ifc$readGray  output  width  local pointer in Gray code (registered)
ifc$readGray__RDY  output  1  constant 1
ifc$level  output  width  (remote binary - local binary) mod 2^width
ifc$error  output  1  sticky: a multi-bit Gray step was detected

Behaviour:
- Decided: one clock. Reset is asynchronous and active-high. Ports are named CLK and RST.
- Reset: all synchronizer stages, gsPrev, remoteBin, localBin, localGray and error go to 0. Therefore level=0, advance__RDY=0, readBin=0, readGray=0. RST asserted mid-operation clears state in the same instant. Operation resumes on the first CLK edge after RST deasserts.
- Synchronizer: grayIn passes through syncStages flops; gs is the last stage. No logic sits between the stages.
- Decode: gsPrev <= gs each cycle. remoteBin <= Gray-to-binary(gs). Binary bit i is the XOR of gs[width-1:i].
- Latency: a grayIn value held stable appears on readBin syncStages+1 edges later.
- Step check: every cycle, d = popcount(gs ^ gsPrev).
  - d=0 or d=1 is legal.
  - d>=2 sets error on the next edge.
  - error stays set until ifc$clearError__ENA.
  - If a set and a clear occur in the same cycle, set wins.
  - The check is suppressed for the first syncStages+1 cycles after reset.
- Local pointer: on ifc$advance__ENA && ifc$advance__RDY, localBin <= localBin+1 (wraps 2^width-1 -> 0). localGray <= next ^ (next>>1), registered in the same edge.
  - ENA while RDY=0 is ignored: pointer unchanged, no error.
- level: combinational from registered remoteBin and localBin, width-bit modular subtraction.
  - Wrap-around is correct for any difference below 2^width.
  - A remote pointer that moves backwards below the local pointer reads as a large level; this is not detected. The producer guarantees this never happens.
- Simultaneous events: an advance and a remoteBin update in the same cycle both take effect. level next cycle = newRemote - (local+1).
- No combinational path from any input to any output except advance__ENA -> (none) and level <- registers only.

Test Plan:
- width=4, syncStages=2: reset, then hold grayIn=0 -> readBin=0, level=0, advance__RDY=0, readGray=0, error=0.
- Drive Gray sequence 0,1,3,2,6 (binary 0..4), one step per 3 cycles -> readBin follows 0..4, each 3 edges after the input change; level=4; no error.
- From level=4, pulse advance 4 times back-to-back -> readGray steps 1,3,2,6; level 3,2,1,0; RDY drops after the 4th; a 5th ENA is ignored (readGray stays 6).
- Wrap: remote 14->15->0 (Gray 9,8,0) with local at 14 -> level 1,2; advancing twice gives readGray=8 then 0; no error.
- Jump grayIn 0x0->0x3 in one step -> error=1 three edges later. Assert clearError in the same cycle as a second 2-bit jump -> error stays 1. Clear alone -> error=0.
- Assert RST mid-stream with level=5 -> all outputs 0 immediately (before the next CLK). After release, with grayIn stable at 5 (binary 6), readBin=6 after 3 edges and no error is flagged.
